// File: rtl/press_classifier.sv
// press_classifier: groups debounced press pulses into single/double/triple command codes.
// Optional build macro PRESS_CMD_FIFO_EN replaces the EMIT hold state with a 4-entry command FIFO.
`default_nettype none

module press_classifier #(
  parameter int WINDOW_CYCLES = 5000000,
  parameter int WIN_W         = 23,
  parameter int MAX_PRESSES   = 3
) (
  input  logic       CLK_FPGA,
  input  logic       RST,
  input  logic       Pulse,
  input  logic       Cmd_ready,
  output logic       Cmd_valid,
  output logic [1:0] Cmd_code,
  output logic [7:0] Drop_cnt,
  output logic       Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    EMIT  = 2'd2
  } state_t;

  localparam logic [WIN_W-1:0] TIMER_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [1:0]       MAX_CNT    = 2'(MAX_PRESSES);

  state_t           state;
  logic [1:0]       count;
  logic [WIN_W-1:0] timer;
  logic [7:0]       drop_cnt;
  logic             drop_evt;

  logic             in_group;
  logic [1:0]       next_count;
  logic             close_pulse;
  logic             close_win;
  logic             close_grp;
  logic [1:0]       close_code;

  // A pulse always wins over a coincident window expiry.
  assign in_group    = (state == IDLE) || (state == COUNT);
  assign next_count  = (state == IDLE) ? 2'd1 : count + 2'd1;
  assign close_pulse = in_group && Pulse && (next_count == MAX_CNT);
  assign close_win   = (state == COUNT) && !Pulse && (timer == TIMER_LAST);
  assign close_grp   = close_pulse || close_win;
  assign close_code  = close_pulse ? next_count : count;

`ifndef PRESS_CMD_FIFO_EN
  logic [1:0] code_q;
`endif

  always_ff @(posedge CLK_FPGA or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      count <= 2'd0;
      timer <= '0;
`ifndef PRESS_CMD_FIFO_EN
      code_q <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE, COUNT: begin
          if (Pulse) begin
            count <= next_count;
            timer <= '0;
          end else if (state == COUNT) begin
            timer <= timer + WIN_W'(1);
          end
          if (close_grp) begin
            timer <= '0;
`ifdef PRESS_CMD_FIFO_EN
            state <= IDLE;
            count <= 2'd0;
`else
            state  <= EMIT;
            code_q <= close_code;
`endif
          end else if (Pulse) begin
            state <= COUNT;
          end
        end
`ifndef PRESS_CMD_FIFO_EN
        EMIT: begin
          if (Cmd_ready) begin
            state  <= IDLE;
            count  <= 2'd0;
            code_q <= 2'd0;
          end
        end
`endif
        default: begin
          state <= IDLE;
          count <= 2'd0;
          timer <= '0;
        end
      endcase
    end
  end

`ifdef PRESS_CMD_FIFO_EN
  logic [1:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] occ;
  logic       push;
  logic       pop;
  logic       full;
  logic       push_ok;

  assign push     = close_grp;
  assign pop      = Cmd_valid && Cmd_ready;
  assign full     = (occ == 3'd4);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok  = push && (!full || pop);
  assign drop_evt = push && full && !pop;

  always_ff @(posedge CLK_FPGA or posedge RST) begin
    if (RST) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 2'd0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= close_code;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (push_ok && !pop)      occ <= occ + 3'd1;
      else if (pop && !push_ok) occ <= occ - 3'd1;
    end
  end

  assign Cmd_valid = (occ != 3'd0);
  assign Cmd_code  = Cmd_valid ? fifo_mem[rd_ptr] : 2'd0;
`else
  assign drop_evt  = Pulse && (state == EMIT);
  assign Cmd_valid = (state == EMIT);
  assign Cmd_code  = code_q;
`endif

  always_ff @(posedge CLK_FPGA or posedge RST) begin
    if (RST) begin
      drop_cnt <= 8'd0;
    end else if (drop_evt && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign Drop_cnt = drop_cnt;
  assign Busy     = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_press_classifier.sv
// tb_press_classifier: directed self-checking bench for press_classifier (WINDOW_CYCLES=16, MAX_PRESSES=3).
`default_nettype none

module tb_press_classifier;

  logic       CLK_FPGA = 1'b0;
  logic       RST = 1'b1;
  logic       Pulse = 1'b0;
  logic       Cmd_ready = 1'b0;
  logic       Cmd_valid;
  logic [1:0] Cmd_code;
  logic [7:0] Drop_cnt;
  logic       Busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK_FPGA = ~CLK_FPGA;

  press_classifier #(
    .WINDOW_CYCLES(16),
    .WIN_W        (5),
    .MAX_PRESSES  (3)
  ) dut (
    .CLK_FPGA (CLK_FPGA),
    .RST      (RST),
    .Pulse    (Pulse),
    .Cmd_ready(Cmd_ready),
    .Cmd_valid(Cmd_valid),
    .Cmd_code (Cmd_code),
    .Drop_cnt (Drop_cnt),
    .Busy     (Busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK_FPGA);
      #1;
    end
  endtask

  task automatic pulse_step();
    Pulse = 1'b1;
    step(1);
    Pulse = 1'b0;
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1);
      chk(tag, Cmd_valid, 0);
    end
  endtask

  initial begin
    RST       = 1'b1;
    Cmd_ready = 1'b1;
    step(2);
    chk("rst_valid", Cmd_valid, 0);
    chk("rst_code",  Cmd_code,  0);
    chk("rst_drop",  Drop_cnt,  0);
    chk("rst_busy",  Busy,      0);
    #2 RST = 1'b0;
    step(10);

    // Single press closes on the window 16 edges later, accepted immediately.
    pulse_step();
    chk("t1_busy", Busy, 1);
    chk("t1_valid0", Cmd_valid, 0);
    idle_check(15, "t1_early");
    step(1);
    chk("t1_valid", Cmd_valid, 1);
    chk("t1_code", Cmd_code, 1);
    step(1);
    chk("t1_done_valid", Cmd_valid, 0);
    chk("t1_done_busy", Busy, 0);
    chk("t1_drop", Drop_cnt, 0);

    // Double press: second pulse restarts the window.
    step(3);
    pulse_step();
    idle_check(4, "t2_gap");
    pulse_step();
    idle_check(15, "t2_early");
    step(1);
    chk("t2_valid", Cmd_valid, 1);
    chk("t2_code", Cmd_code, 2);
    step(1);
    chk("t2_done", Cmd_valid, 0);

    // Triple press closes on the third pulse; fourth pulse starts a new group.
    step(3);
    pulse_step();
    step(2);
    pulse_step();
    step(2);
    pulse_step();
    chk("t3_valid", Cmd_valid, 1);
    chk("t3_code", Cmd_code, 3);
    chk("t3_busy", Busy, 1);
    step(1);
    chk("t3_accept", Cmd_valid, 0);
    step(1);
    pulse_step();
    idle_check(15, "t3_early");
    step(1);
    chk("t3b_valid", Cmd_valid, 1);
    chk("t3b_code", Cmd_code, 1);
    // Pulse on the handshake edge is dropped and opens no group.
    Pulse = 1'b1;
    step(1);
    Pulse = 1'b0;
    chk("hs_pulse_valid", Cmd_valid, 0);
    chk("hs_pulse_busy", Busy, 0);
    chk("hs_pulse_drop", Drop_cnt, 1);
    step(1);
    chk("hs_pulse_busy2", Busy, 0);

    // Pulse exactly on the expiry edge extends the group.
    step(3);
    pulse_step();
    idle_check(15, "t4_early");
    pulse_step();
    chk("t4_coinc_valid", Cmd_valid, 0);
    chk("t4_coinc_busy", Busy, 1);
    idle_check(15, "t4_early2");
    step(1);
    chk("t4_valid", Cmd_valid, 1);
    chk("t4_code", Cmd_code, 2);
    step(1);
    chk("t4_done", Cmd_valid, 0);

    // Back-pressure: pulses during EMIT are dropped, Drop_cnt saturates.
    Cmd_ready = 1'b0;
    step(3);
    pulse_step();
    idle_check(15, "t5_early");
    step(1);
    chk("t5_valid", Cmd_valid, 1);
    chk("t5_code", Cmd_code, 1);
    Pulse = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step(1);
      chk("t5_hold_valid", Cmd_valid, 1);
      chk("t5_hold_code", Cmd_code, 1);
      if (i == 0)   chk("t5_drop_first", Drop_cnt, 2);
      if (i == 252) chk("t5_drop_254", Drop_cnt, 254);
      if (i == 253) chk("t5_drop_255", Drop_cnt, 255);
    end
    Pulse = 1'b0;
    chk("t5_drop_sat", Drop_cnt, 255);
    step(5);
    chk("t5_still_valid", Cmd_valid, 1);
    Cmd_ready = 1'b1;
    step(1);
    chk("t5_accept", Cmd_valid, 0);
    chk("t5_busy", Busy, 0);
    chk("t5_drop_keep", Drop_cnt, 255);

    // Asynchronous reset mid-group discards it.
    step(3);
    pulse_step();
    step(2);
    chk("t6_busy_pre", Busy, 1);
    #2 RST = 1'b1;
    #1;
    chk("t6_async_busy", Busy, 0);
    chk("t6_async_valid", Cmd_valid, 0);
    chk("t6_async_code", Cmd_code, 0);
    chk("t6_async_drop", Drop_cnt, 0);
    step(2);
    chk("t6_hold_busy", Busy, 0);
    RST = 1'b0;
    idle_check(20, "t6_after");
    chk("t6_final_busy", Busy, 0);
    chk("t6_final_drop", Drop_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
